round_sequencer: RTL

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/round_sequencer_pkg.sv | 28 ++
 rtl/round_sequencer_arbiter.sv | 49 ++++
 rtl/round_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : round_sequencer_pkg
// Description : Shared game definitions: FSM phase encoding, LFSR seed and
//               tap mask, and the LFSR step function.
// Revision    : 1.0 - initial release
// ============================================================================
package round_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_ARMED  = 3'd1,
    PH_GO     = 3'd2,
    PH_RESULT = 3'd3,
    PH_WIN    = 3'd4
  } phase_e;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1 map to state bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Maximal-length Fibonacci step: a nonzero state never becomes zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_sequencer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : press_arbiter
// Description : Rising-edge detection of both player switches and round-robin
//               grant when both press in the same cycle.
// Revision    : 1.0 - initial release
// Ports       : clk, reset      clock / synchronous active-high reset
//               p1_sw_i,p2_sw_i debounced player switches (levels)
//               accept_i        FSM consumes a grant this cycle
//               grant_p1_o/_p2_o one-hot press grant (combinational)
// ============================================================================
module press_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic p1_sw_i,
  input  logic p2_sw_i,
  input  logic accept_i,
  output logic grant_p1_o,
  output logic grant_p2_o
);

  logic p1_sw_q, p2_sw_q;
  logic prio_p2_q, prio_p2_d;   // 0: P1 wins a tie, 1: P2 wins a tie
  logic p1_edge, p2_edge;

  assign p1_edge = p1_sw_i & ~p1_sw_q;
  assign p2_edge = p2_sw_i & ~p2_sw_q;

  assign grant_p1_o = p1_edge & (~p2_edge | ~prio_p2_q);
  assign grant_p2_o = p2_edge & (~p1_edge |  prio_p2_q);

  // Pointer moves only when the FSM actually uses the grant, so presses in
  // ignored phases do not disturb fairness.
  always_comb begin
    prio_p2_d = prio_p2_q;
    if (accept_i && grant_p1_o) prio_p2_d = 1'b1;
    else if (accept_i && grant_p2_o) prio_p2_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    // History loads the live inputs during reset so no edge appears on exit.
    p1_sw_q <= p1_sw_i;
    p2_sw_q <= p2_sw_i;
    if (reset) prio_p2_q <= 1'b0;
    else       prio_p2_q <= prio_p2_d;
  end

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : round_sequencer
// Description : Two-player reaction game sequencer: random countdown, reaction
//               window, result hold, match win detection and indicator drive.
// Revision    : 1.0 - initial release
// Ports       : clk, reset          clock / synchronous active-high reset
//               tick_i              timebase enable for all timers
//               start_i, clear_i    round start (edge) / match clear (level)
//               p1_sw_i, p2_sw_i    player switches
//               phase_o             FSM state
//               p1_score_o/p2_score_o, score_evt_o, evt_player_o, evt_up_o
//               led_red_o/led_yellow_o/led_green_o/buzzer_o
//               winner_valid_o, winner_id_o
// ============================================================================
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int MIN_DELAY  = 50,
  parameter int GO_TICKS   = 200,
  parameter int HOLD_TICKS = 50,
  parameter int WIN_SCORE  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic       clear_i,
  input  logic       p1_sw_i,
  input  logic       p2_sw_i,
  output logic [2:0] phase_o,
  output logic [2:0] p1_score_o,
  output logic [2:0] p2_score_o,
  output logic       score_evt_o,
  output logic       evt_player_o,
  output logic       evt_up_o,
  output logic       led_red_o,
  output logic       led_yellow_o,
  output logic       led_green_o,
  output logic       buzzer_o,
  output logic       winner_valid_o,
  output logic       winner_id_o
);

  localparam int C_MAX0 = (MIN_DELAY + 63 > GO_TICKS) ? MIN_DELAY + 63 : GO_TICKS;
  localparam int C_MAX  = (C_MAX0 > HOLD_TICKS) ? C_MAX0 : HOLD_TICKS;
  localparam int CNT_W  = $clog2(C_MAX + 1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [7:0]       lfsr_q;
  logic             start_q;
  logic [2:0]       p1_q, p1_d, p2_q, p2_d;
  logic             evt_q, evt_d, evt_pl_q, evt_pl_d, evt_up_q, evt_up_d;
  logic             win_id_q, win_id_d;
  logic [1:0]       rot_q, rot_d;        // 0 green, 1 yellow, 2 red
  logic [2:0]       rot_cnt_q, rot_cnt_d;
  logic             grant_p1, grant_p2, accept, start_edge;

  assign start_edge = start_i & ~start_q;
  assign accept     = ~clear_i & ((phase_q == PH_ARMED) | (phase_q == PH_GO));

  press_arbiter u_arb (
    .clk        (clk),
    .reset      (reset),
    .p1_sw_i    (p1_sw_i),
    .p2_sw_i    (p2_sw_i),
    .accept_i   (accept),
    .grant_p1_o (grant_p1),
    .grant_p2_o (grant_p2)
  );

  always_comb begin
    phase_d   = phase_q;
    timer_d   = timer_q;
    half_d    = half_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    evt_d     = 1'b0;
    evt_pl_d  = evt_pl_q;
    evt_up_d  = evt_up_q;
    win_id_d  = win_id_q;
    rot_d     = rot_q;
    rot_cnt_d = rot_cnt_q;
    if (clear_i) begin
      phase_d = PH_IDLE;
      timer_d = '0;
      p1_d    = '0;
      p2_d    = '0;
    end else begin
      unique case (phase_q)
        PH_IDLE: begin
          if (start_edge && !p1_sw_i && !p2_sw_i) begin
            timer_d = CNT_W'(MIN_DELAY) + CNT_W'(lfsr_q[5:0]);
            half_d  = timer_d >> 1;
            phase_d = PH_ARMED;
          end
        end
        PH_ARMED: begin
          if (grant_p1 || grant_p2) begin
            // False start: saturating decrement; event only on real change.
            if (grant_p1 && p1_q != 3'd0) begin
              p1_d = p1_q - 3'd1; evt_d = 1'b1; evt_pl_d = 1'b0; evt_up_d = 1'b0;
            end else if (grant_p2 && p2_q != 3'd0) begin
              p2_d = p2_q - 3'd1; evt_d = 1'b1; evt_pl_d = 1'b1; evt_up_d = 1'b0;
            end
            phase_d = PH_RESULT;
            timer_d = CNT_W'(HOLD_TICKS);
          end else if (tick_i) begin
            if (timer_q <= CNT_W'(1)) begin
              phase_d = PH_GO;
              timer_d = CNT_W'(GO_TICKS);
            end else begin
              timer_d = timer_q - CNT_W'(1);
            end
          end
        end
        PH_GO: begin
          // A press in the final tick still counts: press beats expiry.
          if (grant_p1 || grant_p2) begin
            if (grant_p1 && p1_q != 3'(WIN_SCORE)) begin
              p1_d = p1_q + 3'd1; evt_d = 1'b1; evt_pl_d = 1'b0; evt_up_d = 1'b1;
            end else if (grant_p2 && p2_q != 3'(WIN_SCORE)) begin
              p2_d = p2_q + 3'd1; evt_d = 1'b1; evt_pl_d = 1'b1; evt_up_d = 1'b1;
            end
            phase_d = PH_RESULT;
            timer_d = CNT_W'(HOLD_TICKS);
          end else if (tick_i) begin
            if (timer_q <= CNT_W'(1)) begin
              phase_d = PH_RESULT;
              timer_d = CNT_W'(HOLD_TICKS);
            end else begin
              timer_d = timer_q - CNT_W'(1);
            end
          end
        end
        PH_RESULT: begin
          if (tick_i) begin
            if (timer_q <= CNT_W'(1)) begin
              timer_d = '0;
              if (p1_q == 3'(WIN_SCORE) || p2_q == 3'(WIN_SCORE)) begin
                phase_d   = PH_WIN;
                win_id_d  = (p2_q == 3'(WIN_SCORE));
                rot_d     = 2'd0;
                rot_cnt_d = 3'd0;
              end else begin
                phase_d = PH_IDLE;
              end
            end else begin
              timer_d = timer_q - CNT_W'(1);
            end
          end
        end
        PH_WIN: begin
          if (tick_i) begin
            rot_cnt_d = rot_cnt_q + 3'd1;
            if (rot_cnt_q == 3'd7) rot_d = (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;
          end
        end
        default: phase_d = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    start_q <= start_i;
    if (reset) begin
      phase_q   <= PH_IDLE;
      timer_q   <= '0;
      half_q    <= '0;
      lfsr_q    <= LFSR_SEED;
      p1_q      <= '0;
      p2_q      <= '0;
      evt_q     <= 1'b0;
      evt_pl_q  <= 1'b0;
      evt_up_q  <= 1'b0;
      win_id_q  <= 1'b0;
      rot_q     <= 2'd0;
      rot_cnt_q <= 3'd0;
    end else begin
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      half_q    <= half_d;
      lfsr_q    <= lfsr_next(lfsr_q);
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      evt_q     <= evt_d;
      evt_pl_q  <= evt_pl_d;
      evt_up_q  <= evt_up_d;
      win_id_q  <= win_id_d;
      rot_q     <= rot_d;
      rot_cnt_q <= rot_cnt_d;
    end
  end

  assign phase_o        = phase_q;
  assign p1_score_o     = p1_q;
  assign p2_score_o     = p2_q;
  assign score_evt_o    = evt_q;
  assign evt_player_o   = evt_pl_q;
  assign evt_up_o       = evt_up_q;
  assign winner_valid_o = (phase_q == PH_WIN);
  assign winner_id_o    = (phase_q == PH_WIN) & win_id_q;
  assign buzzer_o       = (phase_q == PH_GO);
  assign led_red_o      = (phase_q == PH_ARMED) | ((phase_q == PH_WIN) & (rot_q == 2'd2));
  assign led_yellow_o   = ((phase_q == PH_ARMED) & (timer_q <= half_q)) |
                          ((phase_q == PH_WIN) & (rot_q == 2'd1));
  assign led_green_o    = (phase_q == PH_GO) | ((phase_q == PH_WIN) & (rot_q == 2'd0));

endmodule
`default_nettype wire
